nv_nvdla_sdp_wdma_split: RTL and testbench

Width-down splitter on the SDP write path: accepts one wide word of RATIO 64-bit atoms plus a per-atom valid mask and emits the valid atoms one per cycle on a 65-bit atom interface toward the DMA write packer. It is the transmit-side counterpart of the SDP RDMA atom-to-wide packer. Its output format {mask bit, atom} is the same one that packer consumes. The design is fully registered on the input side and supports one atom per cycle sustained throughput with valid/ready backpressure.

---
 rtl/nv_nvdla_sdp_pkg.sv | 31 +++
 rtl/nv_nvdla_sdp_split_mux.sv | 21 ++
 rtl/nv_nvdla_sdp_wdma_split.sv | 129 ++++++++++++
 tb/tb_nv_nvdla_sdp_wdma_split.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/nv_nvdla_sdp_pkg.sv
// Shared SDP types, default widths and mask helpers for the write-path splitter.
package nv_nvdla_sdp_pkg;

   localparam int unsigned SDP_ATOM_W = 64;
   localparam int unsigned SDP_RATIO  = 4;
   // Mask width at the largest legal RATIO; narrower masks are zero-extended.
   localparam int unsigned SDP_MASK_W = 4;
   localparam int unsigned SDP_CNT_W  = 3;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_EMIT  = 1'b1
   } sdp_split_state_e;

   function automatic logic [SDP_CNT_W-1:0] sdp_popcount(input logic [SDP_MASK_W-1:0] m);
      logic [SDP_CNT_W-1:0] cnt;
      cnt = '0;
      for (int unsigned i = 0; i < SDP_MASK_W; i++) begin
         cnt = cnt + SDP_CNT_W'(m[i]);
      end
      return cnt;
   endfunction

   // True when the set bits form a run starting at bit 0 (zero counts as contiguous).
   function automatic logic sdp_mask_contig(input logic [SDP_MASK_W-1:0] m);
      logic [SDP_MASK_W-1:0] m_inc;
      m_inc = m + SDP_MASK_W'(1);
      return ((m & m_inc) == '0);
   endfunction

endpackage

// File: rtl/nv_nvdla_sdp_split_mux.sv
// RATIO:1 atom select driven by the splitter's emit index.
module nv_nvdla_sdp_split_mux #(
   parameter int unsigned RATIO  = 4,
   parameter int unsigned ATOM_W = 64,
   parameter int unsigned IDX_W  = 2
) (
   input  logic [RATIO*ATOM_W-1:0] i_atoms,
   input  logic [IDX_W-1:0]        i_idx,
   output logic [ATOM_W-1:0]       o_atom_c
);

   always_comb begin
      o_atom_c = '0;
      for (int unsigned i = 0; i < RATIO; i++) begin
         if (i_idx == IDX_W'(i)) begin
            o_atom_c = i_atoms[i*ATOM_W +: ATOM_W];
         end
      end
   end

endmodule

// File: rtl/nv_nvdla_sdp_wdma_split.sv
// Wide-word to atom splitter on the SDP write path; emits valid atoms one per cycle.
// Optional sticky mask-error flag enabled by defining NVDLA_SDP_SPLIT_ERR_EN.
module nv_nvdla_sdp_wdma_split
   import nv_nvdla_sdp_pkg::*;
#(
   parameter int unsigned RATIO  = SDP_RATIO,
   parameter int unsigned ATOM_W = SDP_ATOM_W
) (
   input  logic                          nvdla_core_clk,
   input  logic                          nvdla_core_rstn,
   input  logic                          inp_pvld,
   output logic                          inp_prdy,
   input  logic [RATIO*ATOM_W+RATIO-1:0] inp_data,
   input  logic                          inp_end,
   output logic                          out_pvld,
   input  logic                          out_prdy,
   output logic [ATOM_W:0]               out_data,
   output logic                          out_end
`ifdef NVDLA_SDP_SPLIT_ERR_EN
  ,output logic                          err_mask
`endif
);

   localparam int unsigned IDX_W  = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam int unsigned DATA_W = RATIO * ATOM_W;

   sdp_split_state_e      r_state, w_state_nxt;
   logic [DATA_W-1:0]     r_data, w_data_nxt;
   logic                  r_end, w_end_nxt;
   logic [IDX_W-1:0]      r_idx, w_idx_nxt;
   logic [IDX_W-1:0]      r_cnt_m1, w_cnt_nxt;

   logic [RATIO-1:0]      w_mask;
   logic [SDP_MASK_W-1:0] w_mask_ext;
   logic [SDP_CNT_W-1:0]  w_pop;
   logic                  w_buf_vld;
   logic                  w_last;
   logic                  w_inp_acc;
   logic                  w_out_acc;
   logic                  w_load;
   logic [ATOM_W-1:0]     w_atom;

   assign w_mask     = inp_data[DATA_W +: RATIO];
   assign w_mask_ext = SDP_MASK_W'(w_mask);
   assign w_pop      = sdp_popcount(w_mask_ext);

   assign w_buf_vld = (r_state == ST_EMIT);
   assign w_last    = (r_idx == r_cnt_m1);
   assign inp_prdy  = !w_buf_vld | (out_prdy & w_last);
   assign w_inp_acc = inp_pvld & inp_prdy;
   assign w_out_acc = w_buf_vld & out_prdy;
   // Zero-mask words are consumed without touching the buffer.
   assign w_load    = w_inp_acc & (|w_mask);

   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         r_state  <= ST_EMPTY;
         r_data   <= '0;
         r_end    <= 1'b0;
         r_idx    <= '0;
         r_cnt_m1 <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_data   <= w_data_nxt;
         r_end    <= w_end_nxt;
         r_idx    <= w_idx_nxt;
         r_cnt_m1 <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_data_nxt  = r_data;
      w_end_nxt   = r_end;
      w_idx_nxt   = r_idx;
      w_cnt_nxt   = r_cnt_m1;

      case (r_state)
         ST_EMPTY: begin
            if (w_load) w_state_nxt = ST_EMIT;
         end
         ST_EMIT: begin
            if (w_out_acc && w_last && !w_load) w_state_nxt = ST_EMPTY;
         end
         default: w_state_nxt = ST_EMPTY;
      endcase

      // A load only happens when the buffer is empty or its last atom leaves now.
      if (w_load) begin
         w_data_nxt = inp_data[DATA_W-1:0];
         w_end_nxt  = inp_end;
         w_idx_nxt  = '0;
         w_cnt_nxt  = IDX_W'(w_pop - SDP_CNT_W'(1));
      end else if (w_out_acc && !w_last) begin
         w_idx_nxt = r_idx + IDX_W'(1);
      end
   end

   nv_nvdla_sdp_split_mux #(
      .RATIO  (RATIO),
      .ATOM_W (ATOM_W),
      .IDX_W  (IDX_W)
   ) u_mux (
      .i_atoms  (r_data),
      .i_idx    (r_idx),
      .o_atom_c (w_atom)
   );

   assign out_pvld = w_buf_vld;
   assign out_data = {1'b1, w_atom};
   assign out_end  = w_buf_vld & r_end & w_last;

`ifdef NVDLA_SDP_SPLIT_ERR_EN
   logic r_err, w_err_nxt;

   always_comb begin
      w_err_nxt = r_err;
      if (w_inp_acc && ((w_mask == '0) || !sdp_mask_contig(w_mask_ext))) w_err_nxt = 1'b1;
   end

   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) r_err <= 1'b0;
      else                  r_err <= w_err_nxt;
   end

   assign err_mask = r_err;
`endif

endmodule

// File: tb/tb_nv_nvdla_sdp_wdma_split.sv
// Directed self-checking bench for nv_nvdla_sdp_wdma_split (RATIO=4, ATOM_W=64).
module tb_nv_nvdla_sdp_wdma_split;

   localparam int unsigned RATIO  = 4;
   localparam int unsigned ATOM_W = 64;
   localparam int unsigned DW     = RATIO*ATOM_W + RATIO;

   logic              clk  = 1'b0;
   logic              rstn = 1'b0;
   logic              inp_pvld;
   logic              inp_prdy;
   logic [DW-1:0]     inp_data;
   logic              inp_end;
   logic              out_pvld;
   logic              out_prdy;
   logic [ATOM_W:0]   out_data;
   logic              out_end;
`ifdef NVDLA_SDP_SPLIT_ERR_EN
   logic              err_mask;
`endif

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   always #5 clk = ~clk;

   nv_nvdla_sdp_wdma_split #(.RATIO(RATIO), .ATOM_W(ATOM_W)) dut (
      .nvdla_core_clk  (clk),
      .nvdla_core_rstn (rstn),
      .inp_pvld        (inp_pvld),
      .inp_prdy        (inp_prdy),
      .inp_data        (inp_data),
      .inp_end         (inp_end),
      .out_pvld        (out_pvld),
      .out_prdy        (out_prdy),
      .out_data        (out_data),
      .out_end         (out_end)
`ifdef NVDLA_SDP_SPLIT_ERR_EN
     ,.err_mask        (err_mask)
`endif
   );

   task automatic check_eq(input string tag, input logic [64:0] got, input logic [64:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] atom(input logic [31:0] b, input int i);
      return {b, 32'(i)};
   endfunction

   function automatic logic [64:0] od(input logic [31:0] b, input int i);
      return {1'b1, atom(b, i)};
   endfunction

   function automatic logic [DW-1:0] mk_word(input logic [3:0] m, input logic [31:0] b);
      logic [DW-1:0] w;
      w = '0;
      for (int i = 0; i < 4; i++) w[i*64 +: 64] = atom(b, i);
      w[259:256] = m;
      return w;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic p;
      int   k;
      logic [6:0] pat;

      inp_pvld = 1'b0;
      inp_data = '0;
      inp_end  = 1'b0;
      out_prdy = 1'b1;

      // Reset values
      #2;
      check_eq("rst_inp_prdy", 65'(inp_prdy), 65'd1);
      check_eq("rst_out_pvld", 65'(out_pvld), 65'd0);
      check_eq("rst_out_end",  65'(out_end),  65'd0);
      check_eq("rst_out_data", out_data, {1'b1, 64'h0});
`ifdef NVDLA_SDP_SPLIT_ERR_EN
      check_eq("rst_err", 65'(err_mask), 65'd0);
`endif
      tick; tick;
      rstn = 1'b1;
      tick;

      // Full mask, no backpressure
      inp_pvld = 1'b1; inp_data = mk_word(4'hf, 32'hB0B0_0001); inp_end = 1'b0;
      #1 check_eq("t1_accept_rdy", 65'(inp_prdy), 65'd1);
      tick;
      inp_pvld = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) begin
         check_eq("t1_pvld", 65'(out_pvld), 65'd1);
         check_eq("t1_data", out_data, od(32'hB0B0_0001, i));
         check_eq("t1_inp_prdy", 65'(inp_prdy), 65'(i == 3));
         check_eq("t1_end", 65'(out_end), 65'd0);
         tick;
      end
      check_eq("t1_drain", 65'(out_pvld), 65'd0);

      // Back-to-back masks 3 then 7, end on the second word
      inp_pvld = 1'b1; inp_data = mk_word(4'h3, 32'hB0B0_0002); inp_end = 1'b0;
      #1 check_eq("t2_rdy0", 65'(inp_prdy), 65'd1);
      tick;
      inp_data = mk_word(4'h7, 32'hB0B0_0003); inp_end = 1'b1;
      #1;
      check_eq("t2_a0", out_data, od(32'hB0B0_0002, 0));
      check_eq("t2_rdy_mid", 65'(inp_prdy), 65'd0);
      check_eq("t2_end0", 65'(out_end), 65'd0);
      tick;
      check_eq("t2_a1", out_data, od(32'hB0B0_0002, 1));
      check_eq("t2_rdy_last", 65'(inp_prdy), 65'd1);
      check_eq("t2_end1", 65'(out_end), 65'd0);
      tick;
      inp_pvld = 1'b0; inp_end = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         check_eq("t2_pvld", 65'(out_pvld), 65'd1);
         check_eq("t2_b", out_data, od(32'hB0B0_0003, i));
         check_eq("t2_end", 65'(out_end), 65'(i == 2));
         tick;
      end
      check_eq("t2_drain", 65'(out_pvld), 65'd0);

      // Backpressure pattern 1,0,0,1,1,0,1
      inp_pvld = 1'b1; inp_data = mk_word(4'hf, 32'hB0B0_0004);
      tick;
      inp_pvld = 1'b0;
      pat = 7'b1011001; // bit 0 applied first
      k = 0;
      for (int c = 0; c < 7; c++) begin
         p = pat[c];
         out_prdy = p;
         #1;
         check_eq("t3_pvld", 65'(out_pvld), 65'd1);
         check_eq("t3_data", out_data, od(32'hB0B0_0004, k));
         check_eq("t3_inp_prdy", 65'(inp_prdy), 65'(p && (k == 3)));
         tick;
         if (p) k++;
      end
      out_prdy = 1'b1;
      #1;
      check_eq("t3_count", 65'(k), 65'd4);
      check_eq("t3_drain", 65'(out_pvld), 65'd0);
`ifdef NVDLA_SDP_SPLIT_ERR_EN
      check_eq("t3_err_clean", 65'(err_mask), 65'd0);
`endif

      // Zero mask: consumed, nothing emitted
      inp_pvld = 1'b1; inp_data = mk_word(4'h0, 32'hB0B0_0005); inp_end = 1'b1;
      #1 check_eq("t4_rdy", 65'(inp_prdy), 65'd1);
      tick;
      inp_pvld = 1'b0; inp_end = 1'b0;
      #1;
      check_eq("t4_pvld", 65'(out_pvld), 65'd0);
      check_eq("t4_rdy_after", 65'(inp_prdy), 65'd1);
      check_eq("t4_end", 65'(out_end), 65'd0);
`ifdef NVDLA_SDP_SPLIT_ERR_EN
      check_eq("t4_err", 65'(err_mask), 65'd1);
      tick; tick;
      check_eq("t4_err_sticky", 65'(err_mask), 65'd1);
`endif

      // Non-contiguous mask 5 with end: atoms 0 and 1, end on the second
      inp_pvld = 1'b1; inp_data = mk_word(4'h5, 32'hB0B0_0006); inp_end = 1'b1;
      tick;
      inp_pvld = 1'b0; inp_end = 1'b0;
      #1;
      check_eq("t5_a0", out_data, od(32'hB0B0_0006, 0));
      check_eq("t5_end0", 65'(out_end), 65'd0);
      tick;
      check_eq("t5_a1", out_data, od(32'hB0B0_0006, 1));
      check_eq("t5_end1", 65'(out_end), 65'd1);
      check_eq("t5_rdy1", 65'(inp_prdy), 65'd1);
      tick;
      check_eq("t5_drain", 65'(out_pvld), 65'd0);
`ifdef NVDLA_SDP_SPLIT_ERR_EN
      check_eq("t5_err", 65'(err_mask), 65'd1);
`endif

      // Reset during atom 2 of a full word
      inp_pvld = 1'b1; inp_data = mk_word(4'hf, 32'hB0B0_0007);
      tick;
      inp_pvld = 1'b0;
      tick; tick;
      check_eq("t6_a2", out_data, od(32'hB0B0_0007, 2));
      rstn = 1'b0;
      #1;
      check_eq("t6_rst_pvld", 65'(out_pvld), 65'd0);
      check_eq("t6_rst_rdy", 65'(inp_prdy), 65'd1);
      check_eq("t6_rst_data", out_data, {1'b1, 64'h0});
`ifdef NVDLA_SDP_SPLIT_ERR_EN
      check_eq("t6_rst_err", 65'(err_mask), 65'd0);
`endif
      tick;
      rstn = 1'b1;
      tick;
      check_eq("t6_idle", 65'(out_pvld), 65'd0);
      inp_pvld = 1'b1; inp_data = mk_word(4'h1, 32'hB0B0_0008); inp_end = 1'b1;
      tick;
      inp_pvld = 1'b0; inp_end = 1'b0;
      #1;
      check_eq("t6_single", out_data, od(32'hB0B0_0008, 0));
      check_eq("t6_single_end", 65'(out_end), 65'd1);
      tick;
      check_eq("t6_drain", 65'(out_pvld), 65'd0);
`ifdef NVDLA_SDP_SPLIT_ERR_EN
      check_eq("t6_err_clean", 65'(err_mask), 65'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
